// File: rtl/camera_packet_rx.sv
// Serial receiver for camera pose packets: 8N1 byte assembly, sync hunt, field
// collection with XOR checksum, and atomic publication of all fields.
module camera_packet_rx #(
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIELD_W      = 10,
  parameter int          N_FIELDS     = 6,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int          TIMEOUT_CLKS = 4096
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         rx,
  output logic [N_FIELDS*FIELD_W-1:0]  fields_out,
  output logic                         frame_valid,
  output logic                         frame_error,
  output logic                         busy
);

  localparam int BPF     = (FIELD_W + 7) / 8;
  localparam int N_BYTES = N_FIELDS * BPF;
  localparam int STG_W   = N_BYTES * 8;
  localparam int CNT_W   = $clog2(CLKS_PER_BIT);
  localparam int BC_W    = $clog2(N_BYTES + 1);
  localparam int IC_W    = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BC_W-1:0]  LAST_BYTE = BC_W'(N_BYTES - 1);
  localparam logic [IC_W-1:0]  TO_VAL    = IC_W'(TIMEOUT_CLKS);

  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_state_t;
  typedef enum logic [1:0] {P_HUNT, P_PAYLOAD, P_CHECK} pkt_state_t;

  // Field j (counted from the LSB end) sits in the low FIELD_W bits of its byte group.
  function automatic logic [N_FIELDS*FIELD_W-1:0] unpack_fields(input logic [STG_W-1:0] s);
    logic [N_FIELDS*FIELD_W-1:0] f;
    f = '0;
    for (int j = 0; j < N_FIELDS; j++) f[j*FIELD_W +: FIELD_W] = s[j*BPF*8 +: FIELD_W];
    return f;
  endfunction

  logic             rx_s1, rx_s2, rx_q;
  bit_state_t       bit_state, bit_next;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             cnt_clr, sample, start_evt, done_d, ferr_d;
  logic             byte_done, byte_err;

  pkt_state_t       pkt_state, pkt_next;
  logic [BC_W-1:0]  byte_cnt;
  logic [IC_W-1:0]  idle_cnt;
  logic [7:0]       csum;
  logic [STG_W-1:0] staging;
  logic             timeout, abort;
  logic             valid_d, error_d, clr, shift, load;

  // Bit-level framing
  always_comb begin
    bit_next  = bit_state;
    cnt_clr   = 1'b0;
    sample    = 1'b0;
    start_evt = 1'b0;
    done_d    = 1'b0;
    ferr_d    = 1'b0;
    case (bit_state)
      B_IDLE: begin
        cnt_clr = 1'b1;
        if (rx_q && !rx_s2) begin
          bit_next  = B_START;
          start_evt = 1'b1;
        end
      end
      B_START: begin
        if (cnt == HALF_LAST) begin
          cnt_clr  = 1'b1;
          bit_next = rx_s2 ? B_IDLE : B_DATA;
        end
      end
      B_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_clr = 1'b1;
          sample  = 1'b1;
          if (bit_idx == 3'd7) bit_next = B_STOP;
        end
      end
      B_STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_clr  = 1'b1;
          bit_next = B_IDLE;
          done_d   = rx_s2;
          ferr_d   = !rx_s2;
        end
      end
      default: bit_next = B_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_q      <= 1'b1;
      bit_state <= B_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      byte_done <= 1'b0;
      byte_err  <= 1'b0;
    end else begin
      rx_s1     <= rx;
      rx_s2     <= rx_s1;
      rx_q      <= rx_s2;
      bit_state <= bit_next;
      cnt       <= cnt_clr ? '0 : cnt + 1'b1;
      if (sample) bit_idx <= bit_idx + 1'b1;
      byte_done <= done_d;
      byte_err  <= ferr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (sample) shreg <= {rx_s2, shreg[7:1]};
  end

  // Packet-level framing
  assign timeout = (idle_cnt == TO_VAL);
  assign abort   = byte_err || (timeout && !byte_done);

  always_comb begin
    pkt_next = pkt_state;
    valid_d  = 1'b0;
    error_d  = 1'b0;
    clr      = 1'b0;
    shift    = 1'b0;
    load     = 1'b0;
    case (pkt_state)
      P_HUNT: begin
        if (byte_done && shreg == SYNC_BYTE) begin
          pkt_next = P_PAYLOAD;
          clr      = 1'b1;
        end
      end
      P_PAYLOAD: begin
        if (abort) begin
          error_d  = 1'b1;
          pkt_next = P_HUNT;
        end else if (byte_done) begin
          shift = 1'b1;
          if (byte_cnt == LAST_BYTE) pkt_next = P_CHECK;
        end
      end
      P_CHECK: begin
        if (abort) begin
          error_d  = 1'b1;
          pkt_next = P_HUNT;
        end else if (byte_done) begin
          pkt_next = P_HUNT;
          if (shreg == csum) begin
            valid_d = 1'b1;
            load    = 1'b1;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      default: pkt_next = P_HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_state   <= P_HUNT;
      byte_cnt    <= '0;
      idle_cnt    <= '0;
      fields_out  <= '0;
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      pkt_state   <= pkt_next;
      frame_valid <= valid_d;
      frame_error <= error_d;
      if (clr) byte_cnt <= '0;
      else if (shift) byte_cnt <= byte_cnt + 1'b1;
      // Idle timer only runs inside a packet and restarts at every start bit.
      if (pkt_state == P_HUNT || start_evt) idle_cnt <= '0;
      else if (!timeout) idle_cnt <= idle_cnt + 1'b1;
      if (load) fields_out <= unpack_fields(staging);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) csum <= '0;
    else if (shift) csum <= csum ^ shreg;
    if (shift) staging <= (staging << 8) | STG_W'(shreg);
  end

  assign busy = (pkt_state != P_HUNT);

endmodule
